// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared defaults for the register file write-port arbiter and its users.
package regfile_wport_arbiter_pkg;

    localparam bit DISABLE = 1'b0;
    localparam bit ENABLE  = 1'b1;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 5;
    localparam int REQ_N       = 6;
    localparam int WRITE_N     = 4;
    localparam bit ZERO_REG_EN = ENABLE;

    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    // Pointer width that stays legal for a single requester
    function automatic int rr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // 16-bit add that sticks at all ones instead of wrapping
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? DROP_MAX : s[15:0];
    endfunction

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Requester bus plus register file write-port bus of the arbiter.
interface regfile_wport_arbiter_if #(
    parameter int REQ   = 6,
    parameter int ADDR  = 5,
    parameter int DATA  = 32,
    parameter int WRITE = 4
);
    logic [REQ-1:0]              req_;
    logic [REQ-1:0][ADDR-1:0]    req_addr;
    logic [REQ-1:0][DATA-1:0]    req_data;
    logic [REQ-1:0]              gnt_;
    logic [WRITE-1:0]            we_;
    logic [WRITE-1:0][ADDR-1:0]  waddr;
    logic [WRITE-1:0][DATA-1:0]  wdata;

    modport master (output req_, req_addr, req_data, input gnt_, we_, waddr, wdata);
    modport slave  (input req_, req_addr, req_data, output gnt_, we_, waddr, wdata);
endinterface

// File: rtl/regfile_wport_arbiter_rr_multi_pick.sv
// Combinational multi-grant round-robin picker with zero-register and
// same-address rules. Active-high request/grant.
import regfile_wport_arbiter_pkg::*;

module rr_multi_pick #(
    parameter int REQ      = 6,
    parameter int WRITE    = 4,
    parameter int ADDR     = 5,
    parameter bit ZERO_REG = 1'b1,
    localparam int RRW     = rr_width(REQ)
) (
    input  logic [REQ-1:0]             i_req,
    input  logic [RRW-1:0]             i_ptr,
    input  logic [REQ-1:0][ADDR-1:0]   i_addr,
    output logic [REQ-1:0]             o_gnt,
    output logic [REQ-1:0]             o_zdrop,
    output logic [WRITE-1:0]           o_pvld,
    output logic [WRITE-1:0][RRW-1:0]  o_pidx,
    output logic                       o_any,
    output logic [RRW-1:0]             o_last
);

    int                          w_pos;
    int                          w_n;
    logic [RRW-1:0]              w_idx;
    logic                        w_hit;
    logic [WRITE-1:0][ADDR-1:0]  w_paddr;

    // Scan from the pointer; zero-register writes are always taken, real
    // writes fill ports in scan order unless an earlier pick owns the address
    always_comb begin
        o_gnt   = '0;
        o_zdrop = '0;
        o_pvld  = '0;
        o_pidx  = '0;
        o_any   = 1'b0;
        o_last  = i_ptr;
        w_pos   = 0;
        w_n     = 0;
        w_idx   = '0;
        w_hit   = 1'b0;
        w_paddr = '0;
        for (int j = 0; j < REQ; j++) begin
            w_pos = int'(i_ptr) + j;
            if (w_pos >= REQ) w_pos = w_pos - REQ;
            w_idx = RRW'(w_pos);
            if (i_req[w_idx]) begin
                if (ZERO_REG && (i_addr[w_idx] == '0)) begin
                    o_gnt[w_idx]   = 1'b1;
                    o_zdrop[w_idx] = 1'b1;
                end else if (w_n < WRITE) begin
                    w_hit = 1'b0;
                    for (int p = 0; p < WRITE; p++) begin
                        if ((p < w_n) && (w_paddr[p] == i_addr[w_idx])) w_hit = 1'b1;
                    end
                    if (!w_hit) begin
                        o_gnt[w_idx] = 1'b1;
                        for (int p = 0; p < WRITE; p++) begin
                            if (p == w_n) begin
                                o_pvld[p]  = 1'b1;
                                o_pidx[p]  = w_idx;
                                w_paddr[p] = i_addr[w_idx];
                            end
                        end
                        w_n    = w_n + 1;
                        o_any  = 1'b1;
                        o_last = w_idx;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Round-robin sharing of the register file write ports between requesters.
// Grants are combinational; the write ports are driven from registers one
// cycle after the grant.
import regfile_wport_arbiter_pkg::*;

module regfile_wport_arbiter #(
    parameter int DATA     = DATA_W,
    parameter int ADDR     = ADDR_W,
    parameter int REQ      = REQ_N,
    parameter int WRITE    = WRITE_N,
    parameter bit ZERO_REG = ZERO_REG_EN
) (
    input  logic                    clk,
    input  logic                    reset_,
    regfile_wport_arbiter_if.slave  bus,
    output logic [15:0]             drop_cnt
);

    localparam int RRW = rr_width(REQ);

    logic [RRW-1:0]              r_ptr;
    logic [WRITE-1:0]            r_we;
    logic [WRITE-1:0][ADDR-1:0]  r_waddr;
    logic [WRITE-1:0][DATA-1:0]  r_wdata;
    logic [15:0]                 r_drop;

    logic [REQ-1:0]              w_req;
    logic [REQ-1:0]              w_gnt;
    logic [REQ-1:0]              w_zdrop;
    logic [WRITE-1:0]            w_pvld;
    logic [WRITE-1:0][RRW-1:0]   w_pidx;
    logic                        w_any;
    logic [RRW-1:0]              w_last;
    logic [15:0]                 w_zcnt;

    // Requests are masked during reset so no requester sees a grant
    assign w_req = reset_ ? ~bus.req_ : '0;

    rr_multi_pick #(
        .REQ      (REQ),
        .WRITE    (WRITE),
        .ADDR     (ADDR),
        .ZERO_REG (ZERO_REG)
    ) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .i_addr  (bus.req_addr),
        .o_gnt   (w_gnt),
        .o_zdrop (w_zdrop),
        .o_pvld  (w_pvld),
        .o_pidx  (w_pidx),
        .o_any   (w_any),
        .o_last  (w_last)
    );

    assign bus.gnt_  = ~w_gnt;
    assign bus.we_   = r_we;
    assign bus.waddr = r_waddr;
    assign bus.wdata = r_wdata;
    assign drop_cnt  = r_drop;

    // Number of zero-register writes swallowed this cycle
    always_comb begin
        w_zcnt = '0;
        for (int i = 0; i < REQ; i++) w_zcnt = w_zcnt + 16'(w_zdrop[i]);
    end

    // Output stage: assigned ports fire, idle ports keep their last addr/data
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_we    <= '1;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            for (int k = 0; k < WRITE; k++) begin
                if (w_pvld[k]) begin
                    r_we[k]    <= 1'b0;
                    r_waddr[k] <= bus.req_addr[w_pidx[k]];
                    r_wdata[k] <= bus.req_data[w_pidx[k]];
                end else begin
                    r_we[k]    <= 1'b1;
                end
            end
        end
    end

    // Pointer moves past the last real write; zero drops leave it alone
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_last == RRW'(REQ - 1)) ? '0 : w_last + RRW'(1);
        end
    end

    // Saturating count of dropped zero-register writes
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) r_drop <= '0;
        else         r_drop <= sat_add16(r_drop, w_zcnt);
    end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the arbitration rules.
module tb_regfile_wport_arbiter;
    import regfile_wport_arbiter_pkg::*;

    localparam int REQ   = REQ_N;
    localparam int WRITE = WRITE_N;
    localparam int ADDR  = ADDR_W;
    localparam int DATA  = DATA_W;

    logic        clk    = 1'b0;
    logic        reset_ = 1'b0;
    logic [15:0] drop_cnt;
    int          n_chk  = 0;
    int          n_pass = 0;

    regfile_wport_arbiter_if #(.REQ(REQ), .ADDR(ADDR), .DATA(DATA), .WRITE(WRITE)) bus ();

    regfile_wport_arbiter #(
        .DATA(DATA), .ADDR(ADDR), .REQ(REQ), .WRITE(WRITE), .ZERO_REG(ZERO_REG_EN)
    ) dut (
        .clk      (clk),
        .reset_   (reset_),
        .bus      (bus),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Requester stimulus
    logic [REQ-1:0]  s_req_n = '1;
    logic [ADDR-1:0] s_addr [REQ];
    logic [DATA-1:0] s_data [REQ];

    always_comb begin
        bus.req_ = s_req_n;
        for (int i = 0; i < REQ; i++) begin
            bus.req_addr[i] = s_addr[i];
            bus.req_data[i] = s_data[i];
        end
    end

    // Register file fed by the DUT write ports
    logic [DATA-1:0] d_reg [32];
    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int r = 0; r < 32; r++) d_reg[r] <= '0;
        end else begin
            for (int k = 0; k < WRITE; k++)
                if (!bus.we_[k]) d_reg[bus.waddr[k]] <= bus.wdata[k];
        end
    end

    // Reference model state
    int                          m_ptr;
    int                          m_drop;
    logic [DATA-1:0]             m_reg [32];
    logic [WRITE-1:0]            m_we;
    logic [WRITE-1:0][ADDR-1:0]  m_waddr;
    logic [WRITE-1:0][DATA-1:0]  m_wdata;
    logic [REQ-1:0]              e_gnt_n;
    logic [REQ-1:0]              o_gnt_n;
    int                          e_ports [$];
    int                          e_nz;

    function automatic void model_pick();
        int              order [$];
        logic [ADDR-1:0] used [$];
        bit              dup;
        e_gnt_n = '1;
        e_ports.delete();
        e_nz = 0;
        for (int j = 0; j < REQ; j++) order.push_back((m_ptr + j) % REQ);
        foreach (order[q]) begin
            int i;
            i = order[q];
            if (s_req_n[i] == 1'b0) begin
                if (ZERO_REG_EN && s_addr[i] == '0) begin
                    e_gnt_n[i] = 1'b0;
                    e_nz++;
                end else if (e_ports.size() < WRITE) begin
                    dup = 0;
                    foreach (used[u]) if (used[u] == s_addr[i]) dup = 1;
                    if (!dup) begin
                        e_gnt_n[i] = 1'b0;
                        e_ports.push_back(i);
                        used.push_back(s_addr[i]);
                    end
                end
            end
        end
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_drop = 0; m_we = '1; m_waddr = '0; m_wdata = '0;
        for (int r = 0; r < 32; r++) m_reg[r] = '0;
    endtask

    // One clock: sample grants, advance model and DUT, return at negedge
    task automatic run_cycle();
        logic [WRITE-1:0]            n_we;
        logic [WRITE-1:0][ADDR-1:0]  n_waddr;
        logic [WRITE-1:0][DATA-1:0]  n_wdata;
        #1;
        model_pick();
        o_gnt_n = bus.gnt_;
        n_we = '1; n_waddr = m_waddr; n_wdata = m_wdata;
        foreach (e_ports[k]) begin
            n_we[k]    = 1'b0;
            n_waddr[k] = s_addr[e_ports[k]];
            n_wdata[k] = s_data[e_ports[k]];
        end
        @(posedge clk);
        for (int k = 0; k < WRITE; k++) if (!m_we[k]) m_reg[m_waddr[k]] = m_wdata[k];
        m_we = n_we; m_waddr = n_waddr; m_wdata = n_wdata;
        if (e_ports.size() > 0) m_ptr = (e_ports[e_ports.size()-1] + 1) % REQ;
        m_drop = (m_drop + e_nz > 65535) ? 65535 : m_drop + e_nz;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_ = 1'b0;
        s_req_n = '1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        s_req_n = '0;
        for (int i = 0; i < REQ; i++) begin s_addr[i] = ADDR'(10 + i); s_data[i] = DATA'(i); end
        model_reset();
        @(negedge clk); #1;
        n_chk++; if (bus.gnt_ !== 6'b111111) $display("FAIL rst_gnt: got %b want 111111", bus.gnt_); else n_pass++;
        n_chk++; if (bus.we_ !== 4'b1111) $display("FAIL rst_we: got %b want 1111", bus.we_); else n_pass++;
        n_chk++; if (drop_cnt !== 16'd0) $display("FAIL rst_drop: got %0d want 0", drop_cnt); else n_pass++;
        n_chk++; if (bus.waddr !== '0 || bus.wdata !== '0) $display("FAIL rst_wbus: got %h/%h want 0/0", bus.waddr, bus.wdata); else n_pass++;
        @(negedge clk);
        reset_ = 1'b1;
        run_cycle();
        n_chk++; if (o_gnt_n !== 6'b110000) $display("FAIL rst_first_gnt: got %b want 110000", o_gnt_n); else n_pass++;
        s_req_n = '1;
    endtask

    task automatic test_four_writes();
        logic [WRITE-1:0][ADDR-1:0] exp_a;
        do_reset();
        s_addr[0] = 5'd31; s_addr[1] = 5'd1; s_addr[2] = 5'd2; s_addr[3] = 5'd3;
        for (int i = 0; i < 4; i++) s_data[i] = DATA'(s_addr[i]);
        s_req_n = 6'b110000;
        run_cycle();
        s_req_n = '1;
        exp_a = {5'd3, 5'd2, 5'd1, 5'd31};
        n_chk++; if (o_gnt_n !== 6'b110000) $display("FAIL four_gnt: got %b want 110000", o_gnt_n); else n_pass++;
        n_chk++; if (bus.we_ !== 4'b0000) $display("FAIL four_we: got %b want 0000", bus.we_); else n_pass++;
        n_chk++; if (bus.waddr !== exp_a) $display("FAIL four_waddr: got %h want %h", bus.waddr, exp_a); else n_pass++;
        run_cycle();
        n_chk++; if (bus.we_ !== 4'b1111) $display("FAIL four_idle_we: got %b want 1111", bus.we_); else n_pass++;
        n_chk++;
        if (d_reg[31] !== 32'd31 || d_reg[1] !== 32'd1 || d_reg[2] !== 32'd2 || d_reg[3] !== 32'd3)
            $display("FAIL four_regs: got %0d %0d %0d %0d want 31 1 2 3", d_reg[31], d_reg[1], d_reg[2], d_reg[3]);
        else n_pass++;
    endtask

    task automatic test_all_six();
        logic [WRITE-1:0][ADDR-1:0] exp_a;
        do_reset();
        for (int i = 0; i < REQ; i++) begin s_addr[i] = ADDR'(10 + i); s_data[i] = $urandom(); end
        s_req_n = '0;
        run_cycle();
        n_chk++; if (o_gnt_n !== 6'b110000) $display("FAIL six_gnt1: got %b want 110000", o_gnt_n); else n_pass++;
        s_req_n = s_req_n | ~o_gnt_n;
        run_cycle();
        n_chk++; if (o_gnt_n !== 6'b001111) $display("FAIL six_gnt2: got %b want 001111", o_gnt_n); else n_pass++;
        exp_a = {5'd13, 5'd12, 5'd15, 5'd14};
        n_chk++; if (bus.we_ !== 4'b1100) $display("FAIL six_we2: got %b want 1100", bus.we_); else n_pass++;
        n_chk++; if (bus.waddr !== exp_a) $display("FAIL six_waddr2: got %h want %h", bus.waddr, exp_a); else n_pass++;
        n_chk++; if (bus.wdata[0] !== s_data[4]) $display("FAIL six_wdata2: got %h want %h", bus.wdata[0], s_data[4]); else n_pass++;
        s_req_n = '0;
        run_cycle();
        n_chk++; if (o_gnt_n !== 6'b110000) $display("FAIL six_ptr_wrap: got %b want 110000", o_gnt_n); else n_pass++;
        s_req_n = '1;
        run_cycle();
    endtask

    task automatic test_zero_reg();
        do_reset();
        s_addr[0] = 5'd0; s_data[0] = 32'hdeadbeef;
        s_addr[1] = 5'd5; s_data[1] = 32'h0000_1234;
        s_req_n = 6'b111100;
        run_cycle();
        s_req_n = '1;
        n_chk++; if (o_gnt_n !== 6'b111100) $display("FAIL zero_gnt: got %b want 111100", o_gnt_n); else n_pass++;
        n_chk++; if (bus.we_ !== 4'b1110) $display("FAIL zero_we: got %b want 1110", bus.we_); else n_pass++;
        n_chk++; if (bus.waddr[0] !== 5'd5) $display("FAIL zero_waddr: got %0d want 5", bus.waddr[0]); else n_pass++;
        n_chk++; if (drop_cnt !== 16'd1) $display("FAIL zero_drop: got %0d want 1", drop_cnt); else n_pass++;
        run_cycle();
        n_chk++; if (d_reg[0] !== 32'd0) $display("FAIL zero_reg0: got %h want 0", d_reg[0]); else n_pass++;
        n_chk++; if (d_reg[5] !== 32'h1234) $display("FAIL zero_reg5: got %h want 1234", d_reg[5]); else n_pass++;
    endtask

    task automatic test_conflict();
        do_reset();
        s_addr[1] = 5'd7; s_data[1] = 32'h10;
        s_addr[2] = 5'd7; s_data[2] = 32'h20;
        s_req_n = 6'b111001;
        run_cycle();
        n_chk++; if (o_gnt_n !== 6'b111101) $display("FAIL conf_gnt1: got %b want 111101", o_gnt_n); else n_pass++;
        s_req_n = s_req_n | ~o_gnt_n;
        run_cycle();
        n_chk++; if (o_gnt_n !== 6'b111011) $display("FAIL conf_gnt2: got %b want 111011", o_gnt_n); else n_pass++;
        s_req_n = '1;
        run_cycle();
        n_chk++; if (d_reg[7] !== 32'h20) $display("FAIL conf_reg7: got %h want 20", d_reg[7]); else n_pass++;
    endtask

    task automatic test_starvation();
        int wait3;
        bit r4_gone;
        bit bad;
        do_reset();
        s_addr[0] = 5'd8; s_addr[1] = 5'd9; s_addr[2] = 5'd10;
        s_addr[3] = 5'd11; s_addr[4] = 5'd30; s_addr[5] = 5'd12;
        for (int i = 0; i < REQ; i++) s_data[i] = $urandom();
        s_req_n = 6'b100000;
        wait3 = 0; r4_gone = 0;
        for (int c = 0; c < 8; c++) begin
            run_cycle();
            n_chk++; if (o_gnt_n !== e_gnt_n) $display("FAIL starve_gnt c%0d: got %b want %b", c, o_gnt_n, e_gnt_n); else n_pass++;
            if (r4_gone) begin
                bad = (o_gnt_n[4] !== 1'b1);
                for (int k = 0; k < WRITE; k++) if (!bus.we_[k] && bus.waddr[k] == 5'd30) bad = 1;
                n_chk++; if (bad) $display("FAIL starve_withdraw c%0d: gnt %b we %b want no r4 activity", c, o_gnt_n, bus.we_); else n_pass++;
            end
            wait3++;
            if (!o_gnt_n[3]) begin
                n_chk++; if (wait3 > 3) $display("FAIL starve_bound: got %0d cycles want <= 3", wait3); else n_pass++;
                wait3 = 0;
            end
            for (int i = 0; i < 4; i++) if (!o_gnt_n[i]) s_data[i] = $urandom();
            if (c == 0) begin s_req_n[4] = 1'b1; r4_gone = 1; end
        end
        n_chk++; if (wait3 > 3) $display("FAIL starve_tail: got %0d cycles want <= 3", wait3); else n_pass++;
        s_req_n = '1;
        run_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin s_addr[i] = ADDR'(20 + i); s_data[i] = $urandom(); end
        s_req_n = 6'b110000;
        run_cycle();
        n_chk++; if (bus.we_ !== 4'b0000) $display("FAIL mid_we_pre: got %b want 0000", bus.we_); else n_pass++;
        #2;
        reset_ = 1'b0;
        #1;
        n_chk++; if (bus.we_ !== 4'b1111) $display("FAIL mid_we_rst: got %b want 1111", bus.we_); else n_pass++;
        n_chk++; if (bus.gnt_ !== 6'b111111) $display("FAIL mid_gnt_rst: got %b want 111111", bus.gnt_); else n_pass++;
        s_req_n = '1;
        model_reset();
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            run_cycle();
            n_chk++; if (o_gnt_n !== e_gnt_n) $display("FAIL rnd_gnt c%0d: got %b want %b", c, o_gnt_n, e_gnt_n); else n_pass++;
            n_chk++; if (bus.we_ !== m_we) $display("FAIL rnd_we c%0d: got %b want %b", c, bus.we_, m_we); else n_pass++;
            n_chk++; if (bus.waddr !== m_waddr) $display("FAIL rnd_waddr c%0d: got %h want %h", c, bus.waddr, m_waddr); else n_pass++;
            n_chk++; if (bus.wdata !== m_wdata) $display("FAIL rnd_wdata c%0d: got %h want %h", c, bus.wdata, m_wdata); else n_pass++;
            n_chk++; if (drop_cnt !== 16'(m_drop)) $display("FAIL rnd_drop c%0d: got %0d want %0d", c, drop_cnt, m_drop); else n_pass++;
            for (int i = 0; i < REQ; i++) begin
                if (!s_req_n[i] && !o_gnt_n[i]) begin
                    if ($urandom_range(99) < 60) begin
                        s_addr[i] = ADDR'($urandom_range(7)); s_data[i] = $urandom();
                    end else s_req_n[i] = 1'b1;
                end else if (s_req_n[i]) begin
                    if ($urandom_range(99) < 40) begin
                        s_req_n[i] = 1'b0; s_addr[i] = ADDR'($urandom_range(7)); s_data[i] = $urandom();
                    end
                end else if ($urandom_range(99) < 5) s_req_n[i] = 1'b1;
            end
        end
        s_req_n = '1;
        run_cycle();
        run_cycle();
        for (int r = 0; r < 32; r++) begin
            n_chk++; if (d_reg[r] !== m_reg[r]) $display("FAIL rnd_reg%0d: got %h want %h", r, d_reg[r], m_reg[r]); else n_pass++;
        end
    endtask

    task automatic test_drop_saturate();
        do_reset();
        for (int i = 0; i < REQ; i++) begin s_addr[i] = '0; s_data[i] = $urandom(); end
        s_req_n = '0;
        run_cycle();
        n_chk++; if (o_gnt_n !== 6'b000000) $display("FAIL sat_gnt: got %b want 000000", o_gnt_n); else n_pass++;
        n_chk++; if (drop_cnt !== 16'd6) $display("FAIL sat_first: got %0d want 6", drop_cnt); else n_pass++;
        n_chk++; if (bus.we_ !== 4'b1111) $display("FAIL sat_we: got %b want 1111", bus.we_); else n_pass++;
        repeat (11000) @(negedge clk);
        n_chk++; if (drop_cnt !== 16'hFFFF) $display("FAIL sat_max: got %h want ffff", drop_cnt); else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++; if (drop_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", drop_cnt); else n_pass++;
        s_req_n = '1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < REQ; i++) begin s_addr[i] = '0; s_data[i] = '0; end
        test_reset();
        test_four_writes();
        test_all_six();
        test_zero_reg();
        test_conflict();
        test_starvation();
        test_reset_mid();
        test_random();
        test_drop_saturate();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
